// File: rtl/axis_bram_pingpong_ctrl_if.sv
// Stream-in / BRAM-out signal bundle for the ping-pong write scheduler.
// slave is the controller's view; master is the view of whoever drives it.
interface axis_bram_pingpong_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
);
  logic              EN;
  logic [ADDR_W:0]   CFG_LEN;
  logic [DATA_W-1:0] DIN;
  logic              DIN_VALID;
  logic              DIN_LAST;
  logic              DIN_ACCEP;
  logic              BRAM_WE;
  logic [ADDR_W:0]   BRAM_ADDR;
  logic [DATA_W-1:0] BRAM_DIN;
  logic [1:0]        BANK_FULL;
  logic [1:0]        BANK_RELEASE;
  logic [ADDR_W:0]   LAST_LEN;
  logic              BUSY;

  modport slave (
    input  EN, CFG_LEN, DIN, DIN_VALID, DIN_LAST, BANK_RELEASE,
    output DIN_ACCEP, BRAM_WE, BRAM_ADDR, BRAM_DIN, BANK_FULL, LAST_LEN, BUSY
  );

  modport master (
    output EN, CFG_LEN, DIN, DIN_VALID, DIN_LAST, BANK_RELEASE,
    input  DIN_ACCEP, BRAM_WE, BRAM_ADDR, BRAM_DIN, BANK_FULL, LAST_LEN, BUSY
  );
endinterface

// File: rtl/axis_bram_pingpong_ctrl.sv
// Ping-pong BRAM write scheduler: fills bank 0 then bank 1, flags full banks, stalls on unreleased.
// Optional ABA_LAST_EN: DIN_LAST closes a frame early and LAST_LEN reports words written.
module axis_bram_pingpong_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input logic                     S_AXIS_ACLK,
  input logic                     S_AXIS_ARESET,
  axis_bram_pingpong_ctrl_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DepthLen = (ADDR_W + 1)'(Depth);
  localparam logic [ADDR_W:0] OneLen   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {StIdle, StFill, StWaitBank} state_e;

  state_e              state_q, state_d;
  logic                bank_q, bank_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [1:0]          full_q, full_d;
  logic [1:0]          set_pend_q, set_pend_d;
  logic [ADDR_W:0]     last_len_q, last_len_d;
  logic                we_q;
  logic [ADDR_W:0]     addr_q;
  logic [DATA_W-1:0]   din_q;

  logic                accep;
  logic                beat;
  logic                at_len_end;
  logic                closing;
  logic [ADDR_W:0]     len_cfg;
  logic [ADDR_W:0]     ptr_ext;
  logic [1:0]          set_mask;

  assign accep    = (state_q == StFill);
  assign beat     = bus.DIN_VALID & accep;
  assign ptr_ext  = {1'b0, ptr_q};
  assign len_cfg  = ((bus.CFG_LEN == '0) || (bus.CFG_LEN > DepthLen)) ? DepthLen : bus.CFG_LEN;
  assign at_len_end = (ptr_ext == (len_q - OneLen));
  assign set_mask = bank_q ? 2'b10 : 2'b01;

`ifdef ABA_LAST_EN
  assign closing = beat & (at_len_end | bus.DIN_LAST);
`else
  logic unused_din_last;
  assign unused_din_last = bus.DIN_LAST;
  assign closing = beat & at_len_end;
`endif

  // Flag update: a pending set (from last cycle's close) beats a same-cycle release.
  // This is also the occupancy used for every scheduling decision this cycle.
  assign full_d = (full_q & ~bus.BANK_RELEASE) | set_pend_q;

  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    set_pend_d = 2'b00;
    last_len_d = last_len_q;

    unique case (state_q)
      StIdle: begin
        if (bus.EN) begin
          if (!full_d[bank_q]) begin
            len_d   = len_cfg;
            ptr_d   = '0;
            state_d = StFill;
          end else begin
            state_d = StWaitBank;
          end
        end
      end

      StFill: begin
        if (closing) begin
          bank_d     = ~bank_q;
          ptr_d      = '0;
          set_pend_d = set_mask;
`ifdef ABA_LAST_EN
          last_len_d = ptr_ext + OneLen;
`else
          last_len_d = len_q;
`endif
          if (!bus.EN) begin
            state_d = StIdle;
          end else if (full_d[~bank_q]) begin
            state_d = StWaitBank;
          end else begin
            len_d   = len_cfg;
          end
        end else if (beat) begin
          ptr_d = ptr_q + 1'b1;
        end
      end

      StWaitBank: begin
        if (!full_d[bank_q]) begin
          len_d   = len_cfg;
          ptr_d   = '0;
          state_d = StFill;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state_q    <= StIdle;
      bank_q     <= 1'b0;
      ptr_q      <= '0;
      len_q      <= DepthLen;
      full_q     <= 2'b00;
      set_pend_q <= 2'b00;
      last_len_q <= '0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      full_q     <= full_d;
      set_pend_q <= set_pend_d;
      last_len_q <= last_len_d;
    end
  end

  // Write port is one cycle behind the beat; address uses pre-increment bank/pointer.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      we_q <= beat;
      if (beat) begin
        addr_q <= {bank_q, ptr_q};
        din_q  <= bus.DIN;
      end
    end
  end

  assign bus.DIN_ACCEP = accep;
  assign bus.BRAM_WE   = we_q;
  assign bus.BRAM_ADDR = addr_q;
  assign bus.BRAM_DIN  = din_q;
  assign bus.BANK_FULL = full_q;
  assign bus.LAST_LEN  = last_len_q;
  assign bus.BUSY      = (state_q != StIdle) | we_q;

endmodule

// File: tb/tb_axis_bram_pingpong_ctrl.sv
// Directed bench for axis_bram_pingpong_ctrl: per-cycle vector table plus hand-written sequences.
module tb_axis_bram_pingpong_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  axis_bram_pingpong_ctrl_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  axis_bram_pingpong_ctrl #(.DATA_W(32), .ADDR_W(4)) dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESET (rst),
    .bus           (bus)
  );

  typedef struct {
    logic        en;
    logic [4:0]  cfg;
    logic [31:0] din;
    logic        vld;
    logic        last;
    logic [1:0]  rel;
    logic        e_accep;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_din;
    logic [1:0]  e_full;
    logic [4:0]  e_llen;
    logic        e_busy;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(int en, int cfg, int din, int vld, int last, int rel,
                              int accep, int we, int addr, int bdin, int full, int llen,
                              int busy);
    vec_t v;
    v.en = 1'(en);       v.cfg = 5'(cfg);      v.din = 32'(din);
    v.vld = 1'(vld);     v.last = 1'(last);    v.rel = 2'(rel);
    v.e_accep = 1'(accep); v.e_we = 1'(we);    v.e_addr = 5'(addr);
    v.e_din = 32'(bdin); v.e_full = 2'(full);  v.e_llen = 5'(llen);
    v.e_busy = 1'(busy);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive inputs, clock once, sample 1 ns after the edge.
  task automatic step(input logic en, input logic [4:0] cfg, input logic [31:0] din,
                      input logic vld, input logic last, input logic [1:0] rel);
    bus.EN = en; bus.CFG_LEN = cfg; bus.DIN = din;
    bus.DIN_VALID = vld; bus.DIN_LAST = last; bus.BANK_RELEASE = rel;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic accep, input logic we,
                         input logic [4:0] addr, input logic [31:0] bdin,
                         input logic [1:0] full, input logic [4:0] llen, input logic busy);
    chk({nm, ".accep"}, 32'(bus.DIN_ACCEP), 32'(accep));
    chk({nm, ".we"}, 32'(bus.BRAM_WE), 32'(we));
    if (we) begin
      chk({nm, ".addr"}, 32'(bus.BRAM_ADDR), 32'(addr));
      chk({nm, ".din"}, bus.BRAM_DIN, bdin);
    end
    chk({nm, ".full"}, 32'(bus.BANK_FULL), 32'(full));
    chk({nm, ".last_len"}, 32'(bus.LAST_LEN), 32'(llen));
    chk({nm, ".busy"}, 32'(bus.BUSY), 32'(busy));
  endtask

  task automatic chk_zero(input string nm);
    chk_out(nm, 1'b0, 1'b0, 5'd0, 32'd0, 2'b00, 5'd0, 1'b0);
    chk({nm, ".addr0"}, 32'(bus.BRAM_ADDR), 32'd0);
    chk({nm, ".din0"}, bus.BRAM_DIN, 32'd0);
  endtask

  initial begin
    //            en cfg din vld lst rel | acc we addr bdin full llen busy
    vecs[0]  = mk(1, 4,  0, 0, 0, 0,   1, 0,  0,  0, 0, 0, 1);
    vecs[1]  = mk(1, 4,  0, 1, 0, 0,   1, 1,  0,  0, 0, 0, 1);
    vecs[2]  = mk(1, 4,  1, 1, 0, 0,   1, 1,  1,  1, 0, 0, 1);
    vecs[3]  = mk(1, 4,  2, 1, 0, 0,   1, 1,  2,  2, 0, 0, 1);
    vecs[4]  = mk(1, 4,  3, 1, 0, 0,   1, 1,  3,  3, 0, 4, 1);
    vecs[5]  = mk(1, 4,  4, 1, 0, 0,   1, 1, 16,  4, 1, 4, 1);
    vecs[6]  = mk(1, 4,  5, 1, 0, 0,   1, 1, 17,  5, 1, 4, 1);
    vecs[7]  = mk(1, 4,  6, 1, 0, 0,   1, 1, 18,  6, 1, 4, 1);
    vecs[8]  = mk(1, 4,  7, 1, 0, 0,   0, 1, 19,  7, 1, 4, 1);
    vecs[9]  = mk(1, 4,  8, 1, 0, 0,   0, 0,  0,  0, 3, 4, 1);
    vecs[10] = mk(1, 4,  8, 1, 0, 1,   1, 0,  0,  0, 2, 4, 1);
    vecs[11] = mk(1, 4,  8, 1, 0, 0,   1, 1,  0,  8, 2, 4, 1);
    vecs[12] = mk(1, 4,  9, 1, 0, 0,   1, 1,  1,  9, 2, 4, 1);
    vecs[13] = mk(1, 4, 10, 1, 0, 0,   1, 1,  2, 10, 2, 4, 1);
    vecs[14] = mk(1, 4, 11, 1, 0, 0,   0, 1,  3, 11, 2, 4, 1);
    vecs[15] = mk(1, 4,  0, 0, 0, 2,   1, 0,  0,  0, 1, 4, 1);
    vecs[16] = mk(1, 4,  0, 0, 0, 1,   1, 0,  0,  0, 0, 4, 1);
    vecs[17] = mk(1, 4, 20, 1, 0, 0,   1, 1, 16, 20, 0, 4, 1);
    vecs[18] = mk(0, 4, 21, 1, 0, 0,   1, 1, 17, 21, 0, 4, 1);
    vecs[19] = mk(0, 4, 22, 1, 0, 0,   1, 1, 18, 22, 0, 4, 1);
    vecs[20] = mk(0, 4, 23, 1, 0, 0,   0, 1, 19, 23, 0, 4, 1);
    vecs[21] = mk(0, 4,  0, 0, 0, 0,   0, 0,  0,  0, 2, 4, 0);
    vecs[22] = mk(0, 4, 99, 1, 0, 0,   0, 0,  0,  0, 2, 4, 0);
    vecs[23] = mk(0, 4,  0, 0, 0, 2,   0, 0,  0,  0, 0, 4, 0);

    // Reset state
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk_zero("reset");
    rst = 1'b0;

    // Back-to-back frames, stall on full banks, release, EN drop mid-frame
    for (int i = 0; i < 24; i++) begin
      step(vecs[i].en, vecs[i].cfg, vecs[i].din, vecs[i].vld, vecs[i].last, vecs[i].rel);
      chk_out($sformatf("vec%0d", i), vecs[i].e_accep, vecs[i].e_we, vecs[i].e_addr,
              vecs[i].e_din, vecs[i].e_full, vecs[i].e_llen, vecs[i].e_busy);
    end

    // CFG_LEN=0 and CFG_LEN=20 both give 16-word frames; address wraps 15 -> 16
    step(1, 0, 0, 0, 0, 0);
    chk("len0.start_accep", 32'(bus.DIN_ACCEP), 32'd1);
    for (int i = 0; i < 16; i++) begin
      step(1, (i == 15) ? 5'd20 : 5'd0, 32'(100 + i), 1, 0, 0);
      chk_out($sformatf("len0.w%0d", i), 1'b1, 1'b1, 5'(i), 32'(100 + i), 2'b00,
              (i == 15) ? 5'd16 : 5'd4, 1'b1);
    end
    for (int i = 0; i < 16; i++) begin
      step(1, 20, 32'(200 + i), 1, 0, 0);
      chk_out($sformatf("len20.w%0d", i), (i != 15), 1'b1, 5'(16 + i), 32'(200 + i), 2'b01,
              5'd16, 1'b1);
    end
    step(1, 4, 0, 0, 0, 1);
    chk_out("len20.release", 1'b1, 1'b0, 5'd0, 32'd0, 2'b10, 5'd16, 1'b1);

    // Reset in the middle of a frame (ptr=2)
    step(1, 4, 300, 1, 0, 0);
    chk_out("midrst.w0", 1'b1, 1'b1, 5'd0, 32'd300, 2'b10, 5'd16, 1'b1);
    step(1, 4, 301, 1, 0, 0);
    chk_out("midrst.w1", 1'b1, 1'b1, 5'd1, 32'd301, 2'b10, 5'd16, 1'b1);
    rst = 1'b1;
    step(1, 4, 302, 1, 0, 0);
    chk_zero("midrst");
    rst = 1'b0;
    step(1, 4, 0, 0, 0, 0);
    chk_out("midrst.restart", 1'b1, 1'b0, 5'd0, 32'd0, 2'b00, 5'd0, 1'b1);
    step(1, 4, 77, 1, 0, 0);
    chk_out("midrst.w0again", 1'b1, 1'b1, 5'd0, 32'd77, 2'b00, 5'd0, 1'b1);

    // DIN_LAST on the third beat of an 8-word frame
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(1, 8, 0, 0, 0, 0);
    chk("last.start_accep", 32'(bus.DIN_ACCEP), 32'd1);
    step(1, 8, 50, 1, 0, 0);
    chk_out("last.w0", 1'b1, 1'b1, 5'd0, 32'd50, 2'b00, 5'd0, 1'b1);
    step(1, 8, 51, 1, 0, 0);
    chk_out("last.w1", 1'b1, 1'b1, 5'd1, 32'd51, 2'b00, 5'd0, 1'b1);
    step(1, 8, 52, 1, 1, 0);
`ifdef ABA_LAST_EN
    chk_out("last.w2", 1'b1, 1'b1, 5'd2, 32'd52, 2'b00, 5'd3, 1'b1);
    step(1, 8, 53, 1, 0, 0);
    chk_out("last.next", 1'b1, 1'b1, 5'd16, 32'd53, 2'b01, 5'd3, 1'b1);
`else
    chk_out("last.w2", 1'b1, 1'b1, 5'd2, 32'd52, 2'b00, 5'd0, 1'b1);
    for (int i = 3; i < 8; i++) begin
      step(1, 8, 32'(50 + i), 1, 0, 0);
      chk_out($sformatf("last.w%0d", i), 1'b1, 1'b1, 5'(i), 32'(50 + i), 2'b00,
              (i == 7) ? 5'd8 : 5'd0, 1'b1);
    end
    step(1, 8, 58, 1, 0, 0);
    chk_out("last.next", 1'b1, 1'b1, 5'd16, 32'd58, 2'b01, 5'd8, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
